// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default sizes, the
// zero-register index, an address-width helper and packed-port slice macros.
`ifndef RF_PKG_SV
`define RF_PKG_SV

`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  // Number of address bits needed to index 'value' entries.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) bits++;
    return bits;
  endfunction

endpackage

`endif

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue marks a destination pending, any enabled
// write to that register clears it, and a same-edge issue wins over the clear.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS   = NREGS_DEF,
  parameter  int NWR     = 2,
  parameter  int ZERO_R0 = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] waddr,
  input  logic              iss_vld,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int p = 0; p < NWR; p++) begin
      if (we[p]) clr_vec[`RF_SLICE(waddr, p, AW)] = 1'b1;
    end
    if (iss_vld) set_vec[iss_rd] = 1'b1;
    if (ZERO_R0 != 0) set_vec[REG_ZERO] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_vec <= '0;
    else        busy_vec <= set_vec | (busy_vec & ~clr_vec);
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// hardwired x0 and an integrated busy scoreboard for the pipelined core.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEF,
  parameter  int NREGS   = NREGS_DEF,
  parameter  int NRD     = 2,
  parameter  int NWR     = 2,
  parameter  int BYPASS  = 1,
  parameter  int ZERO_R0 = 1,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_raddr,
  output logic [NRD*XLEN-1:0] o_rdata,
  output logic [NRD-1:0]      o_rbusy,
  input  logic [NWR-1:0]      i_we,
  input  logic [NWR*AW-1:0]   i_waddr,
  input  logic [NWR*XLEN-1:0] i_wdata,
  input  logic                i_iss_vld,
  input  logic [AW-1:0]       i_iss_rd,
  output logic [NREGS-1:0]    o_busy_vec
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREGS];

  // NOTE: the array must read back as zero straight after reset, so it is
  // built from resettable flops rather than an unreset RAM macro.
  // Ports are visited in ascending order, so the highest-index port's
  // assignment is the last one scheduled and wins on an address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (i_we[p] && !((ZERO_R0 != 0) && (`RF_SLICE(i_waddr, p, AW) == ZERO_ADDR)))
          regs[`RF_SLICE(i_waddr, p, AW)] <= `RF_SLICE(i_wdata, p, XLEN);
      end
    end
  end

  rf_scoreboard #(
    .NREGS   (NREGS),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .we       (i_we),
    .waddr    (i_waddr),
    .iss_vld  (i_iss_vld),
    .iss_rd   (i_iss_rd),
    .busy_vec (o_busy_vec)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic            is_zero;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;
    logic [XLEN-1:0] rd_data;

    assign ra      = `RF_SLICE(i_raddr, k, AW);
    assign is_zero = (ZERO_R0 != 0) && (ra == ZERO_ADDR);

    // Youngest matching write port supplies the forwarded value.
    always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int p = 0; p < NWR; p++) begin
        if (i_we[p] && (`RF_SLICE(i_waddr, p, AW) == ra)) begin
          fwd_hit  = 1'b1;
          fwd_data = `RF_SLICE(i_wdata, p, XLEN);
        end
      end
    end

    always_comb begin
      if (is_zero)                     rd_data = '0;
      else if ((BYPASS != 0) && fwd_hit) rd_data = fwd_data;
      else                             rd_data = regs[ra];
    end

    assign `RF_SLICE(o_rdata, k, XLEN) = rd_data;
    // A forwarded completion satisfies the reader, so it no longer waits.
    assign o_rbusy[k] = !is_zero && o_busy_vec[ra] && !((BYPASS != 0) && fwd_hit);
  end

endmodule
